// File: rtl/icache_mshr_txreq_arb.sv
// icache_mshr_txreq_arb
// Round-robin arbiter between the icache MSHR entries and the downstream line-fill bus.
// Granted requests go through a small registered FIFO. Each entry has two line slots (A and B).
// Each slot has an outstanding bit, so a line is never requested twice while it is in flight.
// The last response beat of a line clears its bit and sends a one-cycle done pulse to the entry.
// The payload is carried as a flat vector. Bit 0 of the payload is the lineA flag.
// Optional feature macro: ICACHE_TXREQ_RSP_CHK_EN. When it is defined, rsp_err is built as a
// sticky flag for bad response beats. When it is undefined, rsp_err is tied to 0.
// ENTRY_NUM must be at least 2 so that the entry index field is not empty.
module icache_mshr_txreq_arb #(
    parameter int ENTRY_NUM   = 8,
    parameter int QUEUE_DEPTH = 2,
    parameter int RSP_BEATS   = 4,
    parameter int PLD_W       = 16,
    parameter int IDX_W       = $clog2(ENTRY_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ENTRY_NUM-1:0]            v_txreq_vld,
    output logic [ENTRY_NUM-1:0]            v_txreq_rdy,
    input  logic [ENTRY_NUM-1:0][PLD_W-1:0] v_txreq_pld,
    output logic                            ds_req_vld,
    input  logic                            ds_req_rdy,
    output logic [PLD_W-1:0]                ds_req_pld,
    output logic [IDX_W:0]                  ds_req_txnid,
    input  logic                            ds_rsp_vld,
    output logic                            ds_rsp_rdy,
    input  logic [IDX_W:0]                  ds_rsp_txnid,
    input  logic                            ds_rsp_last,
    output logic [ENTRY_NUM-1:0]            v_linefillA_done,
    output logic [ENTRY_NUM-1:0]            v_linefillB_done,
    output logic                            rsp_err
);

    localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int BEAT_W = $clog2(RSP_BEATS + 1);

    logic [ENTRY_NUM-1:0] out_a;
    logic [ENTRY_NUM-1:0] out_b;
    logic [ENTRY_NUM-1:0] req_line_a;
    logic [ENTRY_NUM-1:0] eligible;
    logic [ENTRY_NUM-1:0] grant;
    logic [ENTRY_NUM-1:0] set_a;
    logic [ENTRY_NUM-1:0] set_b;
    logic [ENTRY_NUM-1:0] clr_a;
    logic [ENTRY_NUM-1:0] clr_b;
    logic [ENTRY_NUM-1:0] done_a_q;
    logic [ENTRY_NUM-1:0] done_b_q;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     winner;
    logic                 any_grant;

    logic [PLD_W-1:0]     q_pld   [QUEUE_DEPTH];
    logic [IDX_W:0]       q_txnid [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     head_ptr;
    logic [CNT_W-1:0]     q_cnt;
    logic                 queue_full;
    logic                 queue_empty;
    logic                 push;
    logic                 pop;

    logic [BEAT_W-1:0]    beat_cnt;
    logic [IDX_W-1:0]     rsp_idx;
    logic                 rsp_line_a;
    logic                 rsp_idx_ok;
    logic                 last_beat;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == QUEUE_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign queue_empty  = (q_cnt == '0);
    assign queue_full   = (q_cnt == CNT_W'(QUEUE_DEPTH));
    assign push         = any_grant & ~queue_full;
    assign pop          = ds_req_vld & ds_req_rdy;
    assign v_txreq_rdy  = grant & {ENTRY_NUM{~queue_full}};
    assign ds_req_vld   = ~queue_empty;
    assign ds_rsp_rdy   = 1'b1;

    assign rsp_idx      = ds_rsp_txnid[IDX_W:1];
    assign rsp_line_a   = ds_rsp_txnid[0];
    assign rsp_idx_ok   = (int'(rsp_idx) < ENTRY_NUM);
    assign last_beat    = ds_rsp_vld & ds_rsp_last;

    assign v_linefillA_done = done_a_q;
    assign v_linefillB_done = done_b_q;

    // An entry may compete only if the line it targets is not already in flight
    always_comb begin
        req_line_a = '0;
        eligible   = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            req_line_a[i] = v_txreq_pld[i][0];
            eligible[i]   = v_txreq_vld[i] & ~(req_line_a[i] ? out_a[i] : out_b[i]);
        end
    end

    // Round-robin pick: the first eligible entry found scanning upward from rr_ptr
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        for (int o = 0; o < ENTRY_NUM; o++) begin
            if (!any_grant && eligible[(int'(rr_ptr) + o) % ENTRY_NUM]) begin
                grant[(int'(rr_ptr) + o) % ENTRY_NUM] = 1'b1;
                winner    = IDX_W'((int'(rr_ptr) + o) % ENTRY_NUM);
                any_grant = 1'b1;
            end
        end
    end

    // Set and clear masks for the outstanding bits, from the request and response sides
    always_comb begin
        set_a = '0;
        set_b = '0;
        clr_a = '0;
        clr_b = '0;
        if (push) begin
            if (req_line_a[winner]) begin
                set_a[winner] = 1'b1;
            end else begin
                set_b[winner] = 1'b1;
            end
        end
        if (last_beat && rsp_idx_ok) begin
            clr_a[rsp_idx] = rsp_line_a;
            clr_b[rsp_idx] = ~rsp_line_a;
        end
    end

    // When the queue is empty, show the most recently popped slot so the outputs hold their last value
    always_comb begin
        head_ptr = rd_ptr;
        if (queue_empty) begin
            head_ptr = (rd_ptr == '0) ? PTR_W'(QUEUE_DEPTH - 1) : rd_ptr - PTR_W'(1);
        end
    end

    assign ds_req_pld   = q_pld[head_ptr];
    assign ds_req_txnid = q_txnid[head_ptr];

    // Advance the rr pointer one past the entry that has just been handshaked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (int'(winner) == ENTRY_NUM - 1) ? '0 : winner + IDX_W'(1);
        end
    end

    // FIFO pointers and occupancy; pushing and popping in the same cycle leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                q_cnt <= q_cnt - CNT_W'(1);
            end
        end
    end

    // FIFO storage, written with the winner's payload and its {entry, lineA} tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < QUEUE_DEPTH; d++) begin
                q_pld[d]   <= '0;
                q_txnid[d] <= '0;
            end
        end else if (push) begin
            q_pld[wr_ptr]   <= v_txreq_pld[winner];
            q_txnid[wr_ptr] <= {winner, req_line_a[winner]};
        end
    end

    // Outstanding bits per entry and line; a set and a clear on different bits both apply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a <= '0;
            out_b <= '0;
        end else begin
            out_a <= (out_a & ~clr_a) | set_a;
            out_b <= (out_b & ~clr_b) | set_b;
        end
    end

    // Done pulses follow one cycle after the last beat and last for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_a_q <= '0;
            done_b_q <= '0;
        end else begin
            done_a_q <= clr_a;
            done_b_q <= clr_b;
        end
    end

    // Count the beats of the current line; the count restarts after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (ds_rsp_vld) begin
            beat_cnt <= ds_rsp_last ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

`ifdef ICACHE_TXREQ_RSP_CHK_EN
    localparam logic [BEAT_W:0] BEATS_C = (BEAT_W + 1)'(RSP_BEATS);

    logic           beat_known;
    logic [BEAT_W:0] beat_next;
    logic           err_now;
    logic           rsp_err_q;

    // Flag a beat whose tag is not in flight, a last beat that arrives early, or a line that runs too long
    always_comb begin
        beat_known = 1'b0;
        if (rsp_idx_ok) begin
            beat_known = rsp_line_a ? out_a[rsp_idx] : out_b[rsp_idx];
        end
        beat_next = {1'b0, beat_cnt} + (BEAT_W + 1)'(1);
        err_now   = ds_rsp_vld &&
                    (!beat_known ||
                     (ds_rsp_last && (beat_next != BEATS_C)) ||
                     (!ds_rsp_last && (beat_next >= BEATS_C)));
    end

    // Once an error is seen, the flag stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (err_now) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_mshr_txreq_arb.sv
// Bench for icache_mshr_txreq_arb with ENTRY_NUM=8, QUEUE_DEPTH=2, RSP_BEATS=4 and PLD_W=16.
// Each test queues the downstream requests and done pulses it expects.
// Monitors pop those queues on negedges and compare them with what the DUT produces.
module tb_icache_mshr_txreq_arb;

    localparam int EN = 8;

    typedef struct packed {
        logic [3:0]  txnid;
        logic [15:0] pld;
    } req_t;

    typedef struct packed {
        logic [7:0] a_mask;
        logic [7:0] b_mask;
    } done_t;

    logic                clk;
    logic                rst_n;
    logic [EN-1:0]       v_txreq_vld;
    logic [EN-1:0]       v_txreq_rdy;
    logic [EN-1:0][15:0] v_txreq_pld;
    logic                ds_req_vld;
    logic                ds_req_rdy;
    logic [15:0]         ds_req_pld;
    logic [3:0]          ds_req_txnid;
    logic                ds_rsp_vld;
    logic                ds_rsp_rdy;
    logic [3:0]          ds_rsp_txnid;
    logic                ds_rsp_last;
    logic [EN-1:0]       v_linefillA_done;
    logic [EN-1:0]       v_linefillB_done;
    logic                rsp_err;

    int    tests_run = 0;
    int    tests_failed = 0;
    req_t  exp_req[$];
    done_t exp_done[$];
    req_t  mon_req;
    done_t mon_done;

`ifdef ICACHE_TXREQ_RSP_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    icache_mshr_txreq_arb #(
        .ENTRY_NUM  (EN),
        .QUEUE_DEPTH(2),
        .RSP_BEATS  (4),
        .PLD_W      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .v_txreq_vld     (v_txreq_vld),
        .v_txreq_rdy     (v_txreq_rdy),
        .v_txreq_pld     (v_txreq_pld),
        .ds_req_vld      (ds_req_vld),
        .ds_req_rdy      (ds_req_rdy),
        .ds_req_pld      (ds_req_pld),
        .ds_req_txnid    (ds_req_txnid),
        .ds_rsp_vld      (ds_rsp_vld),
        .ds_rsp_rdy      (ds_rsp_rdy),
        .ds_rsp_txnid    (ds_rsp_txnid),
        .ds_rsp_last     (ds_rsp_last),
        .v_linefillA_done(v_linefillA_done),
        .v_linefillB_done(v_linefillB_done),
        .rsp_err         (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk_pld(input int i, input logic a);
        logic [7:0] hi;
        logic [6:0] mid;
        hi  = 8'(8'h50 + i);
        mid = 7'(i * 5 + 1);
        return {hi, mid, a};
    endfunction

    function automatic logic [3:0] txn(input int k, input logic a);
        logic [2:0] idx;
        idx = 3'(k);
        return {idx, a};
    endfunction

    // Scoreboard monitor: checks each downstream handshake and each done pulse against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (ds_req_vld && ds_req_rdy) begin
                tests_run++;
                if (exp_req.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL req_unexpected: got txnid %h pld %h, expected no request", ds_req_txnid, ds_req_pld);
                end else begin
                    mon_req = exp_req.pop_front();
                    if ({ds_req_txnid, ds_req_pld} !== {mon_req.txnid, mon_req.pld}) begin
                        tests_failed++;
                        $display("[TB] FAIL req_order: got txnid %h pld %h, expected txnid %h pld %h", ds_req_txnid, ds_req_pld, mon_req.txnid, mon_req.pld);
                    end
                end
            end
            if ((v_linefillA_done != '0) || (v_linefillB_done != '0)) begin
                tests_run++;
                if (exp_done.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL done_unexpected: got A %h B %h, expected no pulse", v_linefillA_done, v_linefillB_done);
                end else begin
                    mon_done = exp_done.pop_front();
                    if ({v_linefillA_done, v_linefillB_done} !== {mon_done.a_mask, mon_done.b_mask}) begin
                        tests_failed++;
                        $display("[TB] FAIL done_pulse: got A %h B %h, expected A %h B %h", v_linefillA_done, v_linefillB_done, mon_done.a_mask, mon_done.b_mask);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic a);
        req_t r;
        r.txnid = txn(k, a);
        r.pld   = mk_pld(k, a);
        exp_req.push_back(r);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        v_txreq_vld = '0;
        ds_rsp_vld  = 1'b0;
        ds_rsp_last = 1'b0;
        ds_req_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        exp_req.delete();
        exp_done.delete();
        #1 rst_n = 1'b1;
    endtask

    // Raise the requested entries and drop each one after its handshake; returns the entries still waiting
    task automatic drive_reqs(input logic [7:0] mask, input logic a, input int budget, output logic [7:0] pend);
        logic [7:0] hs;
        int n;
        pend = mask;
        n    = 0;
        for (int i = 0; i < EN; i++) begin
            if (mask[i]) begin
                v_txreq_vld[i] = 1'b1;
                v_txreq_pld[i] = mk_pld(i, a);
            end
        end
        while (pend != 0 && n < budget) begin
            @(negedge clk);
            hs = v_txreq_vld & v_txreq_rdy & pend;
            @(posedge clk);
            #1;
            v_txreq_vld = v_txreq_vld & ~hs;
            pend        = pend & ~hs;
            n++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_req.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (exp_req.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d requests still owed, expected 0", exp_req.size());
        end
    endtask

    // Send the response beats of one line with last on the final beat, and queue the done pulse it owes
    task automatic send_line(input int k, input logic a, input int beats);
        done_t d;
        for (int b = 1; b <= beats; b++) begin
            ds_rsp_vld   = 1'b1;
            ds_rsp_txnid = txn(k, a);
            ds_rsp_last  = (b == beats);
            if (b == beats) begin
                d.a_mask = a ? 8'(1 << k) : 8'h00;
                d.b_mask = a ? 8'h00 : 8'(1 << k);
                exp_done.push_back(d);
            end
            @(posedge clk);
            #1;
        end
        ds_rsp_vld  = 1'b0;
        ds_rsp_last = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({ds_req_vld, v_txreq_rdy, v_linefillA_done, v_linefillB_done, rsp_err} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in: got vld %b rdy %h doneA %h doneB %h err %b, expected all 0", ds_req_vld, v_txreq_rdy, v_linefillA_done, v_linefillB_done, rsp_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ds_req_vld, ds_req_txnid, rsp_err, ds_rsp_rdy} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL reset_out: got vld %b txnid %h err %b rsp_rdy %b, expected 0 0 0 1", ds_req_vld, ds_req_txnid, rsp_err, ds_rsp_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_line();
        ds_req_rdy     = 1'b1;
        v_txreq_vld[2] = 1'b1;
        v_txreq_pld[2] = mk_pld(2, 1'b1);
        push_exp(2, 1'b1);
        @(negedge clk);
        tests_run++;
        if ({v_txreq_rdy, ds_req_vld} !== {8'h04, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL t1_grant_no_bypass: got rdy %h ds_vld %b, expected 04 0", v_txreq_rdy, ds_req_vld);
        end
        @(posedge clk);
        #1 v_txreq_vld[2] = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ds_req_vld, ds_req_txnid} !== {1'b1, 4'b0101}) begin
            tests_failed++;
            $display("[TB] FAIL t1_issue: got vld %b txnid %h, expected 1 5", ds_req_vld, ds_req_txnid);
        end
        @(posedge clk);
        #1;
        wait_drain();
        send_line(2, 1'b1, 4);
        @(negedge clk);
        tests_run++;
        if ({v_linefillA_done, v_linefillB_done} !== {8'h04, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL t1_done: got A %h B %h, expected A 04 B 00", v_linefillA_done, v_linefillB_done);
        end
        @(negedge clk);
        tests_run++;
        if ({v_linefillA_done, v_linefillB_done, rsp_err} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL t1_one_cycle: got A %h B %h err %b, expected all 0", v_linefillA_done, v_linefillB_done, rsp_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [7:0] pend;
        do_reset();
        ds_req_rdy = 1'b1;
        push_exp(0, 1'b1);
        push_exp(3, 1'b1);
        push_exp(5, 1'b1);
        drive_reqs(8'b0010_1001, 1'b1, 20, pend);
        tests_run++;
        if (pend !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL t2_grants: got pending %h, expected 00", pend);
        end
        v_txreq_vld = 8'b0010_1001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (v_txreq_rdy !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL t2_idle: got rdy %h, expected 00", v_txreq_rdy);
            end
            @(posedge clk);
            #1;
        end
        v_txreq_vld = '0;
        wait_drain();
        send_line(0, 1'b1, 4);
        send_line(3, 1'b1, 4);
        send_line(5, 1'b1, 4);
    endtask

    task automatic test_queue_full();
        logic [7:0] pend;
        ds_req_rdy = 1'b0;
        push_exp(1, 1'b0);
        push_exp(2, 1'b0);
        push_exp(4, 1'b0);
        drive_reqs(8'b0001_0110, 1'b0, 4, pend);
        tests_run++;
        if (pend !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL t3_two_pushes: got pending %h, expected 10", pend);
        end
        @(negedge clk);
        tests_run++;
        if ({v_txreq_rdy, ds_req_vld, ds_req_txnid, ds_req_pld} !== {8'h00, 1'b1, txn(1, 1'b0), mk_pld(1, 1'b0)}) begin
            tests_failed++;
            $display("[TB] FAIL t3_stall: got rdy %h vld %b txnid %h pld %h, expected 00 1 %h %h", v_txreq_rdy, ds_req_vld, ds_req_txnid, ds_req_pld, txn(1, 1'b0), mk_pld(1, 1'b0));
        end
        @(posedge clk);
        #1 ds_req_rdy = 1'b1;
        drive_reqs(8'h10, 1'b0, 10, pend);
        tests_run++;
        if (pend !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL t3_third_grant: got pending %h, expected 00", pend);
        end
        wait_drain();
        send_line(1, 1'b0, 4);
        send_line(2, 1'b0, 4);
        send_line(4, 1'b0, 4);
    endtask

    task automatic test_clear_vs_request();
        logic [7:0] pend;
        done_t d;
        push_exp(1, 1'b0);
        drive_reqs(8'h02, 1'b0, 10, pend);
        wait_drain();
        for (int b = 0; b < 3; b++) begin
            ds_rsp_vld   = 1'b1;
            ds_rsp_txnid = txn(1, 1'b0);
            ds_rsp_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        ds_rsp_last    = 1'b1;
        v_txreq_vld[1] = 1'b1;
        v_txreq_pld[1] = mk_pld(1, 1'b0);
        d.a_mask = 8'h00;
        d.b_mask = 8'h02;
        exp_done.push_back(d);
        @(negedge clk);
        tests_run++;
        if (v_txreq_rdy[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t4_blocked: got rdy %b, expected 0", v_txreq_rdy[1]);
        end
        @(posedge clk);
        #1;
        ds_rsp_vld  = 1'b0;
        ds_rsp_last = 1'b0;
        push_exp(1, 1'b0);
        @(negedge clk);
        tests_run++;
        if ({v_txreq_rdy[1], v_linefillB_done} !== {1'b1, 8'h02}) begin
            tests_failed++;
            $display("[TB] FAIL t4_regrant: got rdy %b doneB %h, expected 1 02", v_txreq_rdy[1], v_linefillB_done);
        end
        @(posedge clk);
        #1 v_txreq_vld[1] = 1'b0;
        wait_drain();
        send_line(1, 1'b0, 4);
    endtask

    task automatic test_rsp_check();
        logic [7:0] pend;
        do_reset();
        ds_req_rdy = 1'b1;
        push_exp(3, 1'b1);
        drive_reqs(8'h08, 1'b1, 10, pend);
        wait_drain();
        send_line(3, 1'b1, 3);
        @(negedge clk);
        tests_run++;
        if ({rsp_err, v_linefillA_done} !== {EXP_ERR, 8'h08}) begin
            tests_failed++;
            $display("[TB] FAIL t5_short_line: got err %b doneA %h, expected %b 08", rsp_err, v_linefillA_done, EXP_ERR);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (rsp_err !== EXP_ERR) begin
            tests_failed++;
            $display("[TB] FAIL t5_sticky: got err %b, expected %b", rsp_err, EXP_ERR);
        end
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        tests_run++;
        if (rsp_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t5_err_reset: got err %b, expected 0", rsp_err);
        end
        @(posedge clk);
        #1;
        ds_rsp_vld   = 1'b1;
        ds_rsp_txnid = txn(6, 1'b0);
        ds_rsp_last  = 1'b0;
        @(posedge clk);
        #1 ds_rsp_vld = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_err !== EXP_ERR) begin
            tests_failed++;
            $display("[TB] FAIL t5_unknown_txnid: got err %b, expected %b", rsp_err, EXP_ERR);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] pend;
        do_reset();
        ds_req_rdy = 1'b1;
        push_exp(0, 1'b1);
        drive_reqs(8'h01, 1'b1, 10, pend);
        wait_drain();
        ds_req_rdy = 1'b0;
        drive_reqs(8'h06, 1'b1, 10, pend);
        @(negedge clk);
        tests_run++;
        if ({pend, ds_req_vld} !== {8'h00, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL t6_setup: got pending %h vld %b, expected 00 1", pend, ds_req_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ds_req_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t6_async_clear: got vld %b, expected 0", ds_req_vld);
        end
        exp_req.delete();
        exp_done.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({ds_req_vld, v_linefillA_done, v_linefillB_done} !== '0) begin
                tests_failed++;
                $display("[TB] FAIL t6_quiet: got vld %b A %h B %h, expected all 0", ds_req_vld, v_linefillA_done, v_linefillB_done);
            end
            @(posedge clk);
            #1;
        end
        ds_req_rdy = 1'b1;
        push_exp(0, 1'b1);
        push_exp(3, 1'b1);
        drive_reqs(8'h09, 1'b1, 10, pend);
        tests_run++;
        if (pend !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL t6_fresh_grants: got pending %h, expected 00", pend);
        end
        wait_drain();
        send_line(0, 1'b1, 4);
        send_line(3, 1'b1, 4);
    endtask

    initial begin
        rst_n        = 1'b0;
        v_txreq_vld  = '0;
        v_txreq_pld  = '0;
        ds_req_rdy   = 1'b0;
        ds_rsp_vld   = 1'b0;
        ds_rsp_txnid = '0;
        ds_rsp_last  = 1'b0;
        test_reset();
        test_single_line();
        test_round_robin();
        test_queue_full();
        test_clear_vs_request();
        test_rsp_check();
        test_reset_mid_op();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ((exp_req.size() != 0) || (exp_done.size() != 0)) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got %0d requests and %0d pulses owed, expected 0 and 0", exp_req.size(), exp_done.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
